serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder: latches two WIDTH-bit operands and a carry-in, then adds one bit per clock, LSB first.
- The per-bit datapath is a full adder built from two half-adder cells plus an OR; a carry flip-flop links successive bits.
- Used as the sequential arithmetic stage that consumes half-adder outputs.
- Start/busy/done handshake to the surrounding controller.

Parameters:
- WIDTH, 8, operand and result width in bits (legal: 2..32).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- CIN  input  1  carry-in; captured on the accepting edge.
- BUSY  output  1  high while state is SHIFT.
- DONE  output  1  one-cycle pulse; SUM/COUT valid.
- SUM  output  WIDTH  registered result; holds until the next result is written.
- COUT  output  1  registered carry-out of the MSB.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is asynchronous and active-high.
- Reset:
  - RST=1 forces state IDLE immediately, regardless of clock.
  - Clears the operand shift registers, the result shift register, the carry flip-flop and the bit counter.
  - SUM=0, COUT=0, BUSY=0, DONE=0.
  - RST asserted mid-operation abandons the addition; no DONE is produced.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - On an edge with START=1: A_SR<=A, B_SR<=B, C<=CIN, CNT<=0, go to SHIFT.
  - START=0: remain in IDLE.
- SHIFT, each edge:
  - s = A_SR[0]^B_SR[0]^C; c = (A_SR[0]&B_SR[0]) | (C&(A_SR[0]^B_SR[0])).
  - R_SR shifts right with s inserted at the MSB; A_SR and B_SR shift right; C<=c; CNT<=CNT+1.
  - On the edge where CNT==WIDTH-1: SUM<={s,R_SR[WIDTH-1:1]}, COUT<=c, go to FIN.
  - SHIFT lasts exactly WIDTH cycles.
- FIN: DONE=1 for exactly one cycle, then IDLE on the next edge.
- Latency: accepting edge = edge 0; DONE is high in the cycle following edge WIDTH; next START is accepted at edge WIDTH+2 at the earliest.
- START is ignored in SHIFT and FIN; operand changes on A/B/CIN after acceptance have no effect.
- SUM/COUT change only on entry to FIN or on reset; they are stable at all other times, including during a subsequent SHIFT.
- Arithmetic: result is modulo 2^WIDTH with carry-out in COUT; {COUT,SUM} = A+B+CIN.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port OVF (1 bit), registered alongside COUT.
  - OVF = carry into MSB XOR carry out of MSB, i.e. two's-complement overflow.
  - Cleared by reset; updated only on entry to FIN.
- Undefined: no OVF port and no associated logic; all other behaviour is identical.

Test Plan:
- Reset mid-op: START with A=8'hAA, B=8'h55, assert RST after 3 SHIFT cycles -> SUM=00, COUT=0, BUSY=0 immediately; no DONE pulse ever follows.
- Basic add: A=8'h3C, B=8'h42, CIN=0 -> DONE in the cycle after edge 8; SUM=8'h7E, COUT=0; BUSY high for exactly 8 cycles.
- Carry ripple: A=8'hFF, B=8'h01, CIN=0 -> SUM=8'h00, COUT=1. A=8'hFF, B=8'hFF, CIN=1 -> SUM=8'hFF, COUT=1.
- Handshake:
  - During SHIFT, hold START=1 and change A/B -> result unaffected.
  - START=1 during FIN is ignored.
  - START held continuously -> the next op is accepted at edge 10; exactly one DONE per accepted op.
- Hold: after a result of 8'h7E, start A=8'h01, B=8'h01 -> SUM stays 8'h7E through SHIFT, becomes 8'h02 at FIN.
- OVF (macro defined): 8'h7F+8'h01 -> SUM=8'h80, OVF=1, COUT=0. 8'h80+8'h80 -> SUM=8'h00, OVF=1, COUT=1. 8'h3C+8'h42 -> OVF=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: latches A/B/CIN and adds one bit per clock, LSB first, through a full adder built from two half adders.
// Optional two's-complement overflow output OVF is enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             COUT,
    output logic             OVF
`else
    output logic             COUT
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, b_sr_reg;
    logic [WIDTH-1:1] r_sr_reg;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;

    logic             p, g, s, t, c, last;
    logic [WIDTH-1:0] r_sr_next;

    half_adder ha_ab (.x(a_sr_reg[0]), .y(b_sr_reg[0]), .s(p), .c(g));
    half_adder ha_pc (.x(p),           .y(c_reg),       .s(s), .c(t));

    assign c    = g | t;
    assign last = (cnt_reg == CW'(WIDTH - 1));
    // Bit 0 of the shifted-in result falls straight into SUM; only the upper bits are retained.
    assign r_sr_next = {s, r_sr_reg};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (START) state_next = SHIFT;
            SHIFT:   if (last)  state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state_reg == SHIFT);
        DONE = (state_reg == FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_sr_reg <= '0;
            b_sr_reg <= '0;
            r_sr_reg <= '0;
            c_reg    <= 1'b0;
            cnt_reg  <= '0;
            SUM      <= '0;
            COUT     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            OVF      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (START) begin
                    a_sr_reg <= A;
                    b_sr_reg <= B;
                    c_reg    <= CIN;
                    cnt_reg  <= '0;
                end
                SHIFT: begin
                    a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    r_sr_reg <= r_sr_next[WIDTH-1:1];
                    c_reg    <= c;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (last) begin
                        SUM  <= r_sr_next;
                        COUT <= c;
`ifdef SERIAL_ADDER_OVF_EN
                        // c_reg is the carry into the MSB on the final bit.
                        OVF  <= c_reg ^ c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random additions against an arithmetic reference.
// Checks OVF as well when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] exp_sum  = '0;
    logic             exp_cout = 1'b0;
    logic             exp_ovf  = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .CIN(cin),
        .BUSY(busy), .DONE(done), .SUM(sum),
`ifdef SERIAL_ADDER_OVF_EN
        .COUT(cout), .OVF(ovf)
`else
        .COUT(cout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called right after a falling edge with the DUT idle; returns right after a falling edge with the DUT idle.
    task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                          input logic ocin, input logic hold);
        longint unsigned total;
        longint signed   stotal;
        logic [WIDTH-1:0] new_sum;
        logic             new_cout, new_ovf;
        int busy_cnt = 0;
        int done_cnt = 0;

        total    = longint'(oa) + longint'(ob) + longint'(ocin);
        new_sum  = total[WIDTH-1:0];
        new_cout = total[WIDTH];
        stotal   = longint'($signed(oa)) + longint'($signed(ob)) + longint'(ocin);
        new_ovf  = (stotal > 127) || (stotal < -128);

        a = oa; b = ob; cin = ocin; start = 1'b1;
        @(posedge clk);
        #1 start = hold;
        for (int k = 0; k <= WIDTH + 1; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k < WIDTH) begin
                check("busy_shift", 33'(busy), 33'(1'b1));
                check("sum_hold",   33'(sum),  33'(exp_sum));
                check("cout_hold",  33'(cout), 33'(exp_cout));
            end else if (k == WIDTH) begin
                check("done_fin", 33'(done), 33'(1'b1));
                check("sum",      33'(sum),  33'(new_sum));
                check("cout",     33'(cout), 33'(new_cout));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf",      33'(ovf),  33'(new_ovf));
`endif
                exp_sum = new_sum; exp_cout = new_cout; exp_ovf = new_ovf;
            end else begin
                check("idle_after", 33'({busy, done}), 33'(2'b00));
            end
            // Operands wander after acceptance; the result must not care.
            if (k <= WIDTH) begin
                a = WIDTH'($urandom());
                b = WIDTH'($urandom());
                cin = 1'($urandom());
            end
        end
        check("busy_cycles", 33'(busy_cnt), 33'(WIDTH));
        check("done_pulses", 33'(done_cnt), 33'(1));
        $display("[TB] op a=%02h b=%02h cin=%0d hold=%0d -> sum=%02h cout=%0d",
                 oa, ob, ocin, hold, sum, cout);
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("rst_sum",  33'(sum),  33'(0));
        check("rst_cout", 33'(cout), 33'(0));
        check("rst_busy", 33'(busy), 33'(0));
        check("rst_done", 33'(done), 33'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h3C, 8'h42, 1'b0, 1'b0);

        // Abandon an addition three cycles into SHIFT.
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_sum",  33'(sum),  33'(0));
        check("midrst_cout", 33'(cout), 33'(0));
        check("midrst_busy", 33'(busy), 33'(0));
        check("midrst_done", 33'(done), 33'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("midrst_no_done", 33'(done_seen), 33'(0));
        $display("[TB] reset mid-op: sum=%02h cout=%0d", sum, cout);

        run_op(8'h3C, 8'h42, 1'b0, 1'b0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b1);
        run_op(8'h3C, 8'h42, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            run_op(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()), 1'($urandom()));
        start = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
